// File: rtl/tag_sysid_regs.sv
// System ID / housekeeping Avalon-MM slave: ID, build timestamp, scratch bank and,
// when SYSID_UPTIME_EN is defined, a prescaled 64-bit uptime counter with coherent reads.
module tag_sysid_regs #(
    parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'd1614243730,
    parameter int          NUM_SCRATCH = 4,
    parameter int          UPTIME_DIV  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [3:0] A_ID = 4'd0;
    localparam logic [3:0] A_TS = 4'd1;

    if (NUM_SCRATCH < 1 || NUM_SCRATCH > 8 || UPTIME_DIV < 1 || UPTIME_DIV > 65535) begin : g_bad_param
        $error("tag_sysid_regs: NUM_SCRATCH must be 1..8 and UPTIME_DIV 1..65535");
    end

    logic [31:0] readdata_q, readdata_d;
    logic        readdatavalid_q, readdatavalid_d;
    logic [31:0] scratch_q [NUM_SCRATCH];
    logic [31:0] scratch_d [NUM_SCRATCH];
    logic [31:0] rdata;

`ifdef SYSID_UPTIME_EN
    localparam logic [3:0]  A_UPLO    = 4'd2;
    localparam logic [3:0]  A_UPHI    = 4'd3;
    localparam logic [3:0]  A_CTRL    = 4'd4;
    localparam logic [3:0]  A_PRESC   = 4'd5;
    localparam logic [15:0] PRESC_TC  = 16'(UPTIME_DIV - 1);

    logic [63:0] uptime_q, uptime_d;
    logic [15:0] presc_q, presc_d;
    logic [31:0] hi_snap_q, hi_snap_d;
    logic        run_q, run_d;
    logic        ctrl_wr;

    assign ctrl_wr = write && (address == A_CTRL) && byteenable[0];

    // Clear is applied after the tick so it wins on a coincident edge.
    always_comb begin
        uptime_d  = uptime_q;
        presc_d   = presc_q;
        run_d     = run_q;
        hi_snap_d = hi_snap_q;
        if (run_q) begin
            if (presc_q == PRESC_TC) begin
                presc_d  = 16'd0;
                uptime_d = uptime_q + 64'd1;
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
        if (ctrl_wr) begin
            run_d = writedata[0];
            if (writedata[1]) begin
                uptime_d = 64'd0;
                presc_d  = 16'd0;
            end
        end
        if (read && (address == A_UPLO)) begin
            hi_snap_d = uptime_q[63:32];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime_q  <= 64'd0;
            presc_q   <= 16'd0;
            hi_snap_q <= 32'd0;
            run_q     <= 1'b1;
        end else begin
            uptime_q  <= uptime_d;
            presc_q   <= presc_d;
            hi_snap_q <= hi_snap_d;
            run_q     <= run_d;
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            scratch_d[i] = scratch_q[i];
            if (write && (address == 4'(8 + i))) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read mux looks only at pre-edge state, so a same-cycle write is not visible.
    always_comb begin
        rdata = 32'd0;
        case (address)
            A_ID:    rdata = ID_VALUE;
            A_TS:    rdata = TIMESTAMP;
`ifdef SYSID_UPTIME_EN
            A_UPLO:  rdata = uptime_q[31:0];
            A_UPHI:  rdata = hi_snap_q;
            A_CTRL:  rdata = {31'd0, run_q};
            A_PRESC: rdata = 32'(UPTIME_DIV);
`endif
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (address == 4'(8 + i)) begin
                        rdata = scratch_q[i];
                    end
                end
            end
        endcase
        readdata_d      = read ? rdata : readdata_q;
        readdatavalid_d = read;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q      <= 32'd0;
            readdatavalid_q <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= 32'd0;
            end
        end else begin
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= scratch_d[i];
            end
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_tag_sysid_regs.sv
// Directed bench for tag_sysid_regs: register-map vector table plus uptime, wrap and reset sequences.
module tb_tag_sysid_regs;

    localparam logic [31:0] ID  = 32'hA5C3_0017;
    localparam logic [31:0] TS  = 32'd1614243730;
    localparam int          NS  = 4;
    localparam int          DIV = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = 4'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    tag_sysid_regs #(
        .ID_VALUE(ID), .TIMESTAMP(TS), .NUM_SCRATCH(NS), .UPTIME_DIV(DIV)
    ) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .readdatavalid(readdatavalid)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rd, input logic wr, input logic [3:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_now(input logic rd, input logic wr, input logic [3:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        read = rd; write = wr; address = addr; writedata = wdata; byteenable = be;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [3:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        @(negedge clock);
        drive_now(rd, wr, addr, wdata, be);
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        read = 1'b0; write = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        read = 1'b0; write = 1'b0; reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

`ifdef SYSID_UPTIME_EN
    localparam logic [63:0] PRE = 64'h0000_0000_FFFF_FFFF;
    logic [63:0] m_up, m_cur;
    logic [15:0] m_pre;
    logic        m_run;
    logic [31:0] m_lo, m_snap;
    logic        preload = 1'b0;

    assign m_cur = preload ? PRE : m_up;

    // Reference uptime model, stepped on the same edges the DUT samples.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_up <= 64'd0; m_pre <= 16'd0; m_run <= 1'b1; m_lo <= 32'd0; m_snap <= 32'd0;
        end else begin
            m_up <= m_cur;
            if (m_run) begin
                if (m_pre == 16'(DIV - 1)) begin
                    m_pre <= 16'd0;
                    m_up  <= m_cur + 64'd1;
                end else begin
                    m_pre <= m_pre + 16'd1;
                end
            end
            if (write && address == 4'd4 && byteenable[0]) begin
                m_run <= writedata[0];
                if (writedata[1]) begin
                    m_up  <= 64'd0;
                    m_pre <= 16'd0;
                end
            end
            if (read && address == 4'd2) begin
                m_lo   <= m_cur[31:0];
                m_snap <= m_cur[63:32];
            end
        end
    end
`endif

    initial begin
        logic [31:0] last;
        logic [31:0] lo_a;
        logic [31:0] hi_a;
        logic        found;

        do_reset();
        @(posedge clock); #1;
        chk("reset readdata", 64'(readdata), 64'd0);
        chk("reset valid", 64'(readdatavalid), 64'd0);

        add(1, 0, 4'd0,  32'd0,          4'hF, ID);
        add(1, 0, 4'd1,  32'd0,          4'hF, TS);
        add(1, 0, 4'd15, 32'd0,          4'hF, 32'd0);
        add(0, 1, 4'd8,  32'hDEAD_BEEF,  4'hF, 32'd0);
        add(1, 0, 4'd8,  32'd0,          4'hF, 32'hDEAD_BEEF);
        add(0, 1, 4'd8,  32'h0000_5500,  4'b0010, 32'd0);
        add(1, 0, 4'd8,  32'd0,          4'hF, 32'hDEAD_55EF);
        add(0, 1, 4'd9,  32'h1122_3344,  4'b1001, 32'd0);
        add(1, 0, 4'd9,  32'd0,          4'hF, 32'h1100_0044);
        add(1, 1, 4'd10, 32'hA5A5_A5A5,  4'hF, 32'd0);
        add(1, 0, 4'd10, 32'd0,          4'hF, 32'hA5A5_A5A5);
        add(0, 1, 4'd11, 32'hCAFE_F00D,  4'b0100, 32'd0);
        add(1, 0, 4'd11, 32'd0,          4'hF, 32'h00FE_0000);
        add(0, 1, 4'd12, 32'hFFFF_FFFF,  4'hF, 32'd0);
        add(1, 0, 4'd12, 32'd0,          4'hF, 32'd0);
        add(0, 1, 4'd0,  32'hFFFF_FFFF,  4'hF, 32'd0);
        add(1, 0, 4'd0,  32'd0,          4'hF, ID);
        add(0, 1, 4'd1,  32'h1234_5678,  4'hF, 32'd0);
        add(1, 0, 4'd1,  32'd0,          4'hF, TS);
        add(0, 1, 4'd6,  32'hFFFF_FFFF,  4'hF, 32'd0);
        add(1, 0, 4'd6,  32'd0,          4'hF, 32'd0);
        add(1, 0, 4'd8,  32'd0,          4'hF, 32'hDEAD_55EF);
        add(1, 0, 4'd9,  32'd0,          4'hF, 32'h1100_0044);

        last = 32'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            chk($sformatf("vec%0d valid", i), 64'(readdatavalid), 64'(vecs[i].rd));
            if (vecs[i].rd) begin
                chk($sformatf("vec%0d data", i), 64'(readdata), 64'(vecs[i].exp));
                last = vecs[i].exp;
            end else begin
                chk($sformatf("vec%0d hold", i), 64'(readdata), 64'(last));
            end
        end
        idle(0);
        @(posedge clock); #1;
        chk("valid drops", 64'(readdatavalid), 64'd0);

`ifndef SYSID_UPTIME_EN
        for (int a = 2; a <= 5; a++) begin
            drive(0, 1, 4'(a), 32'hFFFF_FFFF, 4'hF);
            drive(1, 0, 4'(a), 32'd0, 4'hF);
            chk($sformatf("disabled addr%0d", a), 64'(readdata), 64'd0);
        end
        idle(0);
`else
        do_reset();
        drive(1, 0, 4'd4, 32'd0, 4'hF);
        chk("ctrl reset", 64'(readdata), 64'd1);
        drive(1, 0, 4'd5, 32'd0, 4'hF);
        chk("prescale", 64'(readdata), 64'(DIV));
        idle(35);
        drive(1, 0, 4'd2, 32'd0, 4'hF);
        chk("uptime lo model", 64'(readdata), 64'(m_lo));
        chk("uptime lo near 10", 64'(readdata >= 32'd9 && readdata <= 32'd11), 64'd1);
        drive(1, 0, 4'd3, 32'd0, 4'hF);
        chk("uptime hi", 64'(readdata), 64'd0);

        drive(0, 1, 4'd4, 32'd0, 4'hF);
        drive(1, 0, 4'd2, 32'd0, 4'hF);
        lo_a = readdata;
        chk("stopped lo model", 64'(readdata), 64'(m_lo));
        idle(20);
        drive(1, 0, 4'd2, 32'd0, 4'hF);
        chk("stopped lo frozen", 64'(readdata), 64'(lo_a));
        drive(1, 0, 4'd4, 32'd0, 4'hF);
        chk("ctrl stopped", 64'(readdata), 64'd0);
        drive(0, 1, 4'd4, 32'd1, 4'hF);

        @(negedge clock);
        read = 1'b1; write = 1'b0; address = 4'd2;
        force dut.uptime_q = PRE;
        preload = 1'b1;
        #1 release dut.uptime_q;
        @(posedge clock); #1;
        preload = 1'b0;
        lo_a = readdata;
        chk("wrap0 lo", 64'(readdata), 64'(m_lo));
        drive(1, 0, 4'd3, 32'd0, 4'hF);
        hi_a = readdata;
        chk("wrap0 hi", 64'(readdata), 64'(m_snap));
        chk("wrap0 coherent", 64'({hi_a, lo_a} == PRE || {hi_a, lo_a} == PRE + 64'd1), 64'd1);
        for (int k = 1; k < 4; k++) begin
            drive(1, 0, 4'd2, 32'd0, 4'hF);
            lo_a = readdata;
            chk($sformatf("wrap%0d lo", k), 64'(readdata), 64'(m_lo));
            drive(1, 0, 4'd3, 32'd0, 4'hF);
            hi_a = readdata;
            chk($sformatf("wrap%0d hi", k), 64'(readdata), 64'(m_snap));
            chk($sformatf("wrap%0d coherent", k),
                64'({hi_a, lo_a} >= PRE && {hi_a, lo_a} <= PRE + 64'd2), 64'd1);
        end

        found = 1'b0;
        idle(0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (m_pre == 16'(DIV - 1)) begin
                found = 1'b1;
                break;
            end
        end
        chk("tick found", 64'(found), 64'd1);
        drive_now(0, 1, 4'd4, 32'd3, 4'hF);
        drive(1, 0, 4'd2, 32'd0, 4'hF);
        chk("clear lo model", 64'(readdata), 64'(m_lo));
        chk("clear lo small", 64'(readdata <= 32'd1), 64'd1);
        drive(1, 0, 4'd3, 32'd0, 4'hF);
        chk("clear hi", 64'(readdata), 64'd0);
        drive(1, 0, 4'd4, 32'd0, 4'hF);
        chk("ctrl after clear", 64'(readdata), 64'd1);
        idle(0);
`endif

        drive(1, 0, 4'd0, 32'd0, 4'hF);
        chk("pre-reset id", 64'(readdata), 64'(ID));
        @(negedge clock);
        read = 1'b1; address = 4'd1;
        @(posedge clock); #1;
        chk("pre-reset valid", 64'(readdatavalid), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async reset valid", 64'(readdatavalid), 64'd0);
        chk("async reset data", 64'(readdata), 64'd0);
        @(negedge clock);
        read = 1'b0; reset_n = 1'b1;

        @(negedge clock);
        read = 1'b1; address = 4'd0;
        #2 reset_n = 1'b0;
        @(posedge clock); #1;
        chk("pending read dropped", 64'(readdatavalid), 64'd0);
        chk("pending read data", 64'(readdata), 64'd0);
        @(negedge clock);
        read = 1'b0; reset_n = 1'b1;
        @(posedge clock); #1;
        chk("no late valid", 64'(readdatavalid), 64'd0);
        drive(1, 0, 4'd8, 32'd0, 4'hF);
        chk("scratch0 after reset", 64'(readdata), 64'd0);
        drive(1, 0, 4'd9, 32'd0, 4'hF);
        chk("scratch1 after reset", 64'(readdata), 64'd0);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_sysid_regs.md
# tag_sysid_regs

Parametrised Avalon-MM system identification and housekeeping slave for the TAG computer. Generalises the fixed two-word ID/timestamp responder into a registered register file: build ID and timestamp constants, a free-running 64-bit uptime counter with prescaler and coherent snapshot read, and a configurable bank of byte-writable scratch registers. Sits on the host processor's Avalon interconnect as the control slave software probes at boot.

## Interface
Parameters:
- ID_VALUE, 32'h0000_0000, system ID constant returned at word 0
- TIMESTAMP, 32'd1614243730, build timestamp returned at word 1
- NUM_SCRATCH, 4, number of scratch registers (1..8)
- UPTIME_DIV, 1, uptime prescale divisor (1..65535); counter ticks once per UPTIME_DIV clocks

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  4  word address
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- byteenable  in  4  byte lanes for writes
- readdata  out  32  registered read data
- readdatavalid  out  1  one-cycle pulse qualifying readdata

One clock; reset is asynchronous and active-low.

## Operation
Register map (word address, access):
- 0 ID (RO) = ID_VALUE
- 1 TIMESTAMP (RO) = TIMESTAMP
- 2 UPTIME_LO (RO): returns uptime[31:0]; same edge latches uptime[63:32] into hi_snap
- 3 UPTIME_HI (RO): returns hi_snap
- 4 CONTROL (RW): bit0 run (reset 1); bit1 clear (write-1, self-clearing, reads 0); other bits read 0
- 5 PRESCALE (RO) = UPTIME_DIV
- 8..8+NUM_SCRATCH-1 SCRATCHn (RW), byteenable honoured per lane
- All other addresses: read 0, writes ignored. Writes to RO words ignored.

Uptime:
- Prescaler counts 0..UPTIME_DIV-1 while run=1; tick on terminal count, prescaler then returns to 0. UPTIME_DIV=1: tick every cycle.
- Tick increments 64-bit uptime; wraps 2^64-1 -> 0 silently.
- run=0 freezes both prescaler and uptime.
- Clear (CONTROL write with bit1=1) zeroes uptime and prescaler on that edge; clear wins over a coincident tick. Run bit updated from same write.
- Reading UPTIME_HI without a preceding UPTIME_LO read returns stale hi_snap (reset 0).

Reset (reset_n low, any time, asynchronous): readdata=0, readdatavalid=0, uptime=0, prescaler=0, hi_snap=0, run=1, all scratch=0. Reset mid-transaction drops the pending read; no readdatavalid is issued for it.

## Timing
- Fixed read latency 1: read sampled at edge N -> readdata valid and readdatavalid=1 during cycle N+1. Back-to-back reads every cycle supported. readdata holds last value when readdatavalid=0.
- No waitrequest; every access completes.
- Write takes effect at the sampling edge; readable from next cycle.
- Read and write same cycle, same address: read returns pre-write value.
- UPTIME_LO read returns counter value as of the sampling edge (before that edge's tick); hi_snap captures the matching high word, so the pair is coherent.
- read and write both asserted: both performed.

## Configuration
- SYSID_UPTIME_EN: defined -> uptime counter, prescaler, hi_snap, CONTROL and PRESCALE implemented as above. Undefined -> none of that logic is built; addresses 2-5 read 0 and ignore writes; ID, TIMESTAMP, scratch and read timing unchanged.

## Test plan
- Reset, read addr 0/1/15 -> readdata ID_VALUE, TIMESTAMP, 0, each with readdatavalid exactly one cycle after read.
- Write SCRATCH0=32'hDEAD_BEEF, then byteenable=4'b0010 writedata=32'h0000_5500 -> read 32'hDEAD_55EF; reset -> reads 0.
- UPTIME_DIV=4, run 40 cycles after reset, read LO then HI -> LO=10 (±1 per sampling edge, checked against model), HI=0; write CONTROL=0, wait 20 cycles -> LO unchanged.
- Force uptime to 64'h0000_0000_FFFF_FFFF (via clear then count, or bench preload), read LO on the wrap edge -> LO/HI pair coherent (FFFF_FFFF/0 or 0/1), never 0/0.
- Write CONTROL=3 on a tick cycle -> next LO read 0 or 1 per model, run stays 1; assert reset_n low during an outstanding read -> no readdatavalid, all outputs 0.
- Build without SYSID_UPTIME_EN -> addr 2-5 read 0 after writes; scratch and ID tests still pass.
